// File: rtl/vtregs_if.sv
// Wishbone slave bus bundle for the video terminal register block.
interface vtregs_if;
  logic [15:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/vtregs.sv
// Video terminal control registers: cursor, control/status, scroll, blink and beep timers.
module vtregs #(
  parameter int unsigned CURW      = 13,
  parameter int unsigned BLINK_DIV = 12500000,
  parameter int unsigned BEEP_LEN  = 5000000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  vtregs_if.slave         bus,
  input  logic [2:0]      initspeed,
  output logic [CURW-1:0] cursor,
  output logic [15:0]     vtcsr,
  output logic [7:0]      scroll,
  output logic            blink,
  output logic            beep
);

  localparam int unsigned BLW = $clog2(BLINK_DIV);
  localparam int unsigned BPW = $clog2(BEEP_LEN + 1);

  logic            ack_q;
  logic [15:0]     dat_q;
  logic [CURW-1:0] cursor_q;
  logic [7:0]      scroll_q;
  logic            csr_b0_q, csr_b2_q, csr_b3_q;
  logic [2:0]      speed_q;
  logic [BLW-1:0]  blink_cnt_q;
  logic            blink_q;
  logic [BPW-1:0]  beep_cnt_q;
  logic [BPW-1:0]  beep_cnt_nxt;
  logic            beep_q;

  logic            access_c;
  logic            wr_c;
  logic [1:0]      reg_sel_c;
  logic            csr_even_wr_c;
  logic [15:0]     rd_c;
  logic [CURW-1:0] cursor_nxt;
  logic            unused_bits;

  // Bus qualifiers: a transaction is taken only while no ack is pending
  assign access_c      = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
  assign wr_c          = access_c & bus.wb_we_i;
  assign reg_sel_c     = bus.wb_adr_i[2:1];
  assign csr_even_wr_c = wr_c & (reg_sel_c == 2'd1) & bus.wb_sel_i[0];
  assign unused_bits   = ^{bus.wb_adr_i[15:3], bus.wb_adr_i[0], bus.wb_dat_i};

  assign vtcsr = {5'b0, speed_q, 2'b00, blink_q, beep_q, csr_b3_q, csr_b2_q, 1'b0, csr_b0_q};

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign cursor       = cursor_q;
  assign scroll       = scroll_q;
  assign blink        = blink_q;
  assign beep         = beep_q;

  // Read data mux
  always_comb begin
    rd_c = 16'h0000;
    case (reg_sel_c)
      2'd0: rd_c = 16'(cursor_q);
      2'd1: rd_c = vtcsr;
      2'd2: rd_c = {8'h00, scroll_q};
      2'd3: rd_c = {13'b0, beep_q, blink_q, csr_b0_q};
      default: rd_c = 16'h0000;
    endcase
  end

  // Byte-lane merge of write data into the cursor; bits above CURW-1 are dropped
  always_comb begin
    cursor_nxt = cursor_q;
    for (int i = 0; i < int'(CURW); i++) begin
      if ((i < 8) ? bus.wb_sel_i[0] : bus.wb_sel_i[1]) cursor_nxt[i] = bus.wb_dat_i[i];
    end
  end

  // Bus handshake, read data capture and register writes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 16'h0000;
      cursor_q <= '0;
      scroll_q <= 8'h00;
      csr_b0_q <= 1'b1;
      csr_b2_q <= 1'b0;
      csr_b3_q <= 1'b0;
      speed_q  <= initspeed;
    end else begin
      ack_q <= access_c;
      if (access_c) dat_q <= rd_c;
      if (wr_c) begin
        case (reg_sel_c)
          2'd0: cursor_q <= cursor_nxt;
          2'd1: begin
            if (bus.wb_sel_i[0]) begin
              csr_b0_q <= bus.wb_dat_i[0];
              csr_b2_q <= bus.wb_dat_i[2];
              csr_b3_q <= bus.wb_dat_i[3];
            end
            if (bus.wb_sel_i[1]) speed_q <= bus.wb_dat_i[10:8];
          end
          2'd2: if (bus.wb_sel_i[0]) scroll_q <= bus.wb_dat_i[7:0];
          default: ;
        endcase
      end
    end
  end

  // Free-running blink divider toggling the blink phase on terminal count
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLW'(1);
    end
  end

  // Beep counter next value; a control write overrides the decrement
  always_comb begin
    beep_cnt_nxt = beep_cnt_q;
    if (csr_even_wr_c) beep_cnt_nxt = bus.wb_dat_i[4] ? BPW'(BEEP_LEN) : '0;
    else if (beep_cnt_q != '0) beep_cnt_nxt = beep_cnt_q - BPW'(1);
  end

  // Beep counter and its registered nonzero flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_nxt;
      beep_q     <= (beep_cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_vtregs.sv
// Directed bench for vtregs: register vector table plus beep, blink, handshake and reset sequences.
module tb_vtregs;

  logic        clk;
  logic        rst;
  logic [2:0]  initspeed;
  logic [12:0] cursor;
  logic [15:0] vtcsr;
  logic [7:0]  scroll;
  logic        blink;
  logic        beep;

  int total = 0;
  int bad   = 0;

  vtregs_if bif();

  vtregs #(.CURW(13), .BLINK_DIV(4), .BEEP_LEN(6)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bif.slave),
    .initspeed(initspeed),
    .cursor   (cursor),
    .vtcsr    (vtcsr),
    .scroll   (scroll),
    .blink    (blink),
    .beep     (beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic [15:0] exp_rd;
    logic [15:0] exp_cur;
    logic [7:0]  exp_scr;
    logic [15:0] exp_csr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bif.wb_cyc_i = 1'b0;
    bif.wb_stb_i = 1'b0;
    bif.wb_we_i  = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                       input logic [1:0] sel);
    bif.wb_cyc_i = 1'b1;
    bif.wb_stb_i = 1'b1;
    bif.wb_we_i  = we;
    bif.wb_adr_i = adr;
    bif.wb_dat_i = dat;
    bif.wb_sel_i = sel;
  endtask

  // One single-beat transaction; reports ack latency and blink phase at the access edge
  task automatic bus(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                     input logic [1:0] sel, output logic [15:0] rd, output int lat,
                     output logic bpre);
    @(negedge clk);
    drive(we, adr, dat, sel);
    bpre = blink;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bif.wb_ack_o && lat < 4);
    if (!bif.wb_ack_o) chk("ack_timeout", 32'd0, 32'd1);
    rd = bif.wb_dat_o;
    @(negedge clk);
    idle();
  endtask

  function automatic void add(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                              input logic [1:0] sel, input logic [15:0] exp_rd,
                              input logic [15:0] exp_cur, input logic [7:0] exp_scr,
                              input logic [15:0] exp_csr);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.exp_rd = exp_rd; v.exp_cur = exp_cur; v.exp_scr = exp_scr; v.exp_csr = exp_csr;
    vt.push_back(v);
  endfunction

  // Beep history over 16 cycles: control write at cycle 0, optional second write at c2
  task automatic beep_run(input int c2, input logic [15:0] d2, output logic [15:0] hist,
                          output int trk);
    trk = 0;
    hist = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 16'h0002, 16'h0411, 2'b11);
      else if (c == c2) drive(1'b1, 16'h0002, d2, 2'b11);
      else idle();
      @(posedge clk);
      #1;
      hist[c] = beep;
      if (vtcsr[4] !== beep) trk++;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] exp;
    logic [15:0] hist;
    logic [5:0]  ackpat;
    logic        bpre;
    logic        prev;
    int          lat;
    int          trk;
    int          last;
    int          toggles;
    int          ierr;

    rst = 1'b1;
    initspeed = 3'b100;
    bif.wb_adr_i = 16'h0000;
    bif.wb_dat_i = 16'h0000;
    bif.wb_sel_i = 2'b00;
    idle();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cursor", 32'(cursor), 32'h0);
    chk("rst_scroll", 32'(scroll), 32'h0);
    chk("rst_vtcsr", 32'(vtcsr), 32'h0401);
    chk("rst_ack", 32'(bif.wb_ack_o), 32'h0);
    chk("rst_dat_o", 32'(bif.wb_dat_o), 32'h0);
    chk("rst_beep_blink", 32'({beep, blink}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    bus(1'b0, 16'h0002, 16'h0000, 2'b11, rd, lat, bpre);
    chk("rst_vtcsr_read", 32'(rd), 32'(16'h0401 | (16'(bpre) << 5)));
    chk("ack_latency", 32'(lat), 32'd1);

    // Register map vectors
    add(0, 16'h0000, 16'h0000, 2'b11, 16'h0000, 16'h0000, 8'h00, 16'h0401);
    add(0, 16'h0004, 16'h0000, 2'b11, 16'h0000, 16'h0000, 8'h00, 16'h0401);
    add(0, 16'h0006, 16'h0000, 2'b11, 16'h0001, 16'h0000, 8'h00, 16'h0401);
    add(1, 16'h0000, 16'hFFFF, 2'b11, 16'h0000, 16'h1FFF, 8'h00, 16'h0401);
    add(0, 16'h0000, 16'h0000, 2'b11, 16'h1FFF, 16'h1FFF, 8'h00, 16'h0401);
    add(1, 16'h0000, 16'h0012, 2'b01, 16'h0000, 16'h1F12, 8'h00, 16'h0401);
    add(0, 16'hFFF8, 16'h0000, 2'b11, 16'h1F12, 16'h1F12, 8'h00, 16'h0401);
    add(1, 16'h0001, 16'hABCD, 2'b10, 16'h0000, 16'h0B12, 8'h00, 16'h0401);
    add(0, 16'h0000, 16'h0000, 2'b11, 16'h0B12, 16'h0B12, 8'h00, 16'h0401);
    add(1, 16'h0006, 16'hFFFF, 2'b11, 16'h0000, 16'h0B12, 8'h00, 16'h0401);
    add(0, 16'h0002, 16'h0000, 2'b11, 16'h0401, 16'h0B12, 8'h00, 16'h0401);
    add(0, 16'h0004, 16'h0000, 2'b11, 16'h0000, 16'h0B12, 8'h00, 16'h0401);
    add(1, 16'h0004, 16'hAB37, 2'b11, 16'h0000, 16'h0B12, 8'h37, 16'h0401);
    add(0, 16'h0004, 16'h0000, 2'b11, 16'h0037, 16'h0B12, 8'h37, 16'h0401);
    add(1, 16'h0004, 16'h12FF, 2'b10, 16'h0000, 16'h0B12, 8'h37, 16'h0401);
    add(0, 16'h0005, 16'h0000, 2'b11, 16'h0037, 16'h0B12, 8'h37, 16'h0401);
    add(1, 16'h0002, 16'hFFEF, 2'b11, 16'h0000, 16'h0B12, 8'h37, 16'h070D);
    add(0, 16'h0002, 16'h0000, 2'b11, 16'h070D, 16'h0B12, 8'h37, 16'h070D);
    add(0, 16'h0006, 16'h0000, 2'b11, 16'h0001, 16'h0B12, 8'h37, 16'h070D);
    add(1, 16'h0002, 16'h0000, 2'b01, 16'h0000, 16'h0B12, 8'h37, 16'h0700);
    add(0, 16'h0002, 16'h0000, 2'b11, 16'h0700, 16'h0B12, 8'h37, 16'h0700);
    add(0, 16'h0006, 16'h0000, 2'b11, 16'h0000, 16'h0B12, 8'h37, 16'h0700);
    add(1, 16'h0002, 16'h0401, 2'b11, 16'h0000, 16'h0B12, 8'h37, 16'h0401);
    add(0, 16'h000A, 16'h0000, 2'b11, 16'h0401, 16'h0B12, 8'h37, 16'h0401);

    for (int i = 0; i < vt.size(); i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd, lat, bpre);
      if (!vt[i].we) begin
        exp = vt[i].exp_rd;
        if (vt[i].adr[2:1] == 2'd1) exp = exp | (16'(bpre) << 5);
        if (vt[i].adr[2:1] == 2'd3) exp = exp | (16'(bpre) << 1);
        chk($sformatf("vec%0d_read", i), 32'(rd), 32'(exp));
      end
      chk($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vt[i].exp_cur));
      chk($sformatf("vec%0d_scroll", i), 32'(scroll), 32'(vt[i].exp_scr));
      chk($sformatf("vec%0d_vtcsr", i), 32'(vtcsr & 16'hFFDF), 32'(vt[i].exp_csr));
    end

    // Held strobe is acknowledged every second cycle
    @(negedge clk);
    drive(1'b0, 16'h0004, 16'h0000, 2'b11);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      ackpat[c] = bif.wb_ack_o;
    end
    @(negedge clk);
    idle();
    chk("ack_pattern", 32'(ackpat), 32'h15);

    // Beep length, re-trigger and clear
    beep_run(-1, 16'h0000, hist, trk);
    chk("beep_single", 32'(hist), 32'h003F);
    chk("beep_track_single", 32'(trk), 32'd0);
    beep_run(3, 16'h0411, hist, trk);
    chk("beep_retrigger", 32'(hist), 32'h01FF);
    chk("beep_track_retrig", 32'(trk), 32'd0);
    beep_run(2, 16'h0401, hist, trk);
    chk("beep_clear", 32'(hist), 32'h0003);

    // Blink period of 4 cycles, unaffected by a write with bit 5 set
    prev = blink;
    last = -1;
    toggles = 0;
    ierr = 0;
    trk = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 5) drive(1'b1, 16'h0002, 16'h0421, 2'b11);
      else idle();
      @(posedge clk);
      #1;
      if (vtcsr[5] !== blink) trk++;
      if (blink !== prev) begin
        if (last >= 0 && (c - last) != 4) ierr++;
        last = c;
        toggles++;
        prev = blink;
      end
    end
    @(negedge clk);
    idle();
    chk("blink_interval", 32'(ierr), 32'd0);
    chk("blink_toggles", 32'(toggles), 32'd6);
    chk("blink_track", 32'(trk), 32'd0);
    chk("blink_write_vtcsr", 32'(vtcsr & 16'hFFDF), 32'h0401);

    // Reset asserted during a pending write
    @(negedge clk);
    initspeed = 3'b010;
    drive(1'b1, 16'h0000, 16'h1234, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cursor_now", 32'(cursor), 32'h0);
    chk("midrst_scroll_now", 32'(scroll), 32'h0);
    chk("midrst_vtcsr_now", 32'(vtcsr), 32'h0201);
    chk("midrst_ack_now", 32'(bif.wb_ack_o), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_ack_edge", 32'(bif.wb_ack_o), 32'h0);
    chk("midrst_cursor_edge", 32'(cursor), 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 16'h0000, 16'h0000, 2'b11, rd, lat, bpre);
    chk("postrst_cursor_read", 32'(rd), 32'h0);
    chk("postrst_ack_latency", 32'(lat), 32'd1);
    bus(1'b0, 16'h0002, 16'h0000, 2'b11, rd, lat, bpre);
    chk("postrst_vtcsr_read", 32'(rd), 32'(16'h0201 | (16'(bpre) << 5)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
